// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int ARB_AW      = 32;
  localparam int ARB_DW      = 32;
  localparam int ARB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_WAIT = 2'd1,
    ST_D_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  // On a tie the port that did not win last time is served.
  function automatic grant_e pick_grant(input logic if_pend, input logic d_pend,
                                        input grant_e last);
    if (if_pend && d_pend) return (last == GNT_IF) ? GNT_D : GNT_IF;
    return d_pend ? GNT_D : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory side of the arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_word_we;
  logic          d_byte_we;
  logic [DW-1:0] d_rdata;
  logic          d_valid;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_word_we;
  logic          mem_byte_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          stall;
  logic          mem_err;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  d_req, d_addr, d_wdata, d_word_we, d_byte_we,
    output d_rdata, d_valid,
    output mem_req, mem_addr, mem_wdata, mem_word_we, mem_byte_we,
    input  mem_rdata, mem_ready,
    output stall, mem_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output d_req, d_addr, d_wdata, d_word_we, d_byte_we,
    input  d_rdata, d_valid,
    input  mem_req, mem_addr, mem_wdata, mem_word_we, mem_byte_we,
    output mem_rdata, mem_ready,
    input  stall, mem_err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Counts WAIT cycles without mem_ready; expired flags the cycle whose increment reaches TIMEOUT.
module arb_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + CW'(1);
    end
  end

  // Looks one step ahead so the abort lands on the edge where the count would hit TIMEOUT.
  assign expired = (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and D ports, one latched request at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  grant_e        grant;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_word_we_q, mem_word_we_d;
  logic          mem_byte_we_q, mem_byte_we_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          mem_err_q, mem_err_d;
  logic          tmo_clear, tmo_enable, tmo_expired;
  logic          if_pend, d_pend;

  // A request whose valid is showing this cycle is already served.
  assign if_pend = bus.if_req & ~if_valid_q;
  assign d_pend  = bus.d_req & ~d_valid_q;
  assign grant   = pick_grant(if_pend, d_pend, last_grant_q);

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_word_we_d = mem_word_we_q;
    mem_byte_we_d = mem_byte_we_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_valid_d    = 1'b0;
    d_valid_d     = 1'b0;
    mem_err_d     = mem_err_q;
    tmo_clear     = 1'b0;
    tmo_enable    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (if_pend || d_pend) begin
          tmo_clear    = 1'b1;
          mem_req_d    = 1'b1;
          last_grant_d = grant;
          if (grant == GNT_D) begin
            state_d       = ST_D_WAIT;
            mem_addr_d    = bus.d_addr;
            mem_wdata_d   = bus.d_wdata;
            mem_word_we_d = bus.d_word_we;
            mem_byte_we_d = bus.d_byte_we;
          end else begin
            state_d       = ST_IF_WAIT;
            mem_addr_d    = bus.if_addr;
            mem_word_we_d = 1'b0;
            mem_byte_we_d = 1'b0;
          end
        end
      end

      ST_IF_WAIT, ST_D_WAIT: begin
        if (bus.mem_ready) begin
          state_d       = ST_IDLE;
          mem_req_d     = 1'b0;
          mem_word_we_d = 1'b0;
          mem_byte_we_d = 1'b0;
          if (state_q == ST_IF_WAIT) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_word_we_q && !mem_byte_we_q) d_rdata_d = bus.mem_rdata;
          end
        end else begin
          tmo_enable = 1'b1;
          if (tmo_expired) begin
            state_d       = ST_IDLE;
            mem_req_d     = 1'b0;
            mem_word_we_d = 1'b0;
            mem_byte_we_d = 1'b0;
            mem_err_d     = 1'b1;
            if (state_q == ST_IF_WAIT) begin
              if_valid_d = 1'b1;
              if_rdata_d = '0;
            end else begin
              d_valid_d = 1'b1;
              d_rdata_d = '0;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_IF;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_word_we_q <= 1'b0;
      mem_byte_we_q <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_valid_q    <= 1'b0;
      d_valid_q     <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_word_we_q <= mem_word_we_d;
      mem_byte_we_q <= mem_byte_we_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_valid_q    <= if_valid_d;
      d_valid_q     <= d_valid_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_word_we = mem_word_we_q;
  assign bus.mem_byte_we = mem_byte_we_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall       = if_pend | d_pend;

endmodule
